// File: rtl/spi_slave_port.sv
// rtl/spi_slave_port.sv - mode-0 byte SPI slave oversampled in the clk domain
module spi_slave_port #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       chip_enable,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       frame_active
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
    logic       sclk_d, cs_d;
    logic       sclk_s, mosi_s, cs_s;
    logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [2:0] bit_cnt;
    logic [7:0] rx_sr, rx_next, tx_sr;
    logic       skip_fall;
    logic       miso_r;

    // Equal-depth synchronizers keep mosi aligned with the detected sclk edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], chip_enable};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign rx_next   = {rx_sr[6:0], mosi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cs_fall) state_next = ACTIVE;
            ACTIVE:  if (cs_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        frame_active = (state == ACTIVE);
        miso_oe      = (state == ACTIVE);
        miso         = miso_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= 3'd0;
            rx_sr     <= 8'h00;
            tx_sr     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            tx_load   <= 1'b0;
            skip_fall <= 1'b0;
            miso_r    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_load  <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt   <= 3'd0;
                    skip_fall <= 1'b0;
                    miso_r    <= 1'b0;
                    if (cs_fall) begin
                        tx_sr   <= tx_data;
                        tx_load <= 1'b1;
                        miso_r  <= tx_data[7];
                    end
                end
                ACTIVE: begin
                    if (sclk_rise) begin
                        rx_sr <= rx_next;
                        if (bit_cnt == 3'd7) begin
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                            bit_cnt  <= 3'd0;
                            // The reloaded MSB must survive the next falling edge
                            if (!cs_rise) begin
                                tx_sr     <= tx_data;
                                tx_load   <= 1'b1;
                                skip_fall <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    if (sclk_fall) begin
                        if (skip_fall) begin
                            skip_fall <= 1'b0;
                            miso_r    <= tx_sr[7];
                        end else begin
                            tx_sr  <= {tx_sr[6:0], 1'b0};
                            miso_r <= tx_sr[6];
                        end
                    end
                    if (cs_rise) begin
                        bit_cnt   <= 3'd0;
                        skip_fall <= 1'b0;
                        miso_r    <= 1'b0;
                    end
                end
                default: begin
                    bit_cnt <= 3'd0;
                    miso_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_port.sv
// tb/tb_spi_slave_port.sv - scoreboard bench for spi_slave_port
module tb_spi_slave_port;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       chip_enable = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       miso, miso_oe, rx_valid, tx_load, frame_active;
    logic [7:0] rx_data;
    logic [7:0] tx_data = 8'h00;

    int tests_run = 0;
    int tests_failed = 0;
    int rx_count = 0;
    int tx_load_count = 0;
    logic rx_valid_prev = 1'b0;
    logic tx_load_prev = 1'b0;
    logic [7:0] rx_expect_q[$];

    spi_slave_port #(.SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .chip_enable(chip_enable),
        .sclk(sclk),
        .mosi(mosi),
        .miso(miso),
        .miso_oe(miso_oe),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .tx_data(tx_data),
        .tx_load(tx_load),
        .frame_active(frame_active)
    );

    always #5 clk = ~clk;

    // Scoreboard: every rx_valid pops the oldest expected byte
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_count++;
            tests_run++;
            if (rx_expect_q.size() == 0) begin
                tests_failed++;
                $display("FAIL rx_unexpected: got rx_data=%02h, required no rx_valid", rx_data);
            end else begin
                logic [7:0] exp;
                exp = rx_expect_q.pop_front();
                if (rx_data !== exp) begin
                    tests_failed++;
                    $display("FAIL rx_data: got %02h, required %02h", rx_data, exp);
                end
            end
            tests_run++;
            if (rx_valid_prev !== 1'b0) begin
                tests_failed++;
                $display("FAIL rx_valid_width: pulse longer than 1 cycle");
            end
        end
        if (tx_load) begin
            tx_load_count++;
            tests_run++;
            if (tx_load_prev !== 1'b0) begin
                tests_failed++;
                $display("FAIL tx_load_width: pulse longer than 1 cycle");
            end
        end
        rx_valid_prev = rx_valid;
        tx_load_prev  = tx_load;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit cs_on_last,
                            output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            wait_cycles(8);
            mi = {mi[6:0], miso};
            sclk = 1'b1;
            if (cs_on_last && i == nbits - 1) chip_enable = 1'b1;
            wait_cycles(8);
            sclk = 1'b0;
        end
    endtask

    task automatic select_frame();
        chip_enable = 1'b0;
        wait_cycles(8);
    endtask

    task automatic deselect_frame();
        wait_cycles(8);
        chip_enable = 1'b1;
        wait_cycles(10);
    endtask

    task automatic check_reset_outputs(input string tag);
        tests_run++;
        if ({miso, miso_oe, rx_valid, tx_load, frame_active} !== 5'b0 || rx_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL %s: got miso=%b oe=%b rxv=%b txl=%b fa=%b rx=%02h, required all 0",
                     tag, miso, miso_oe, rx_valid, tx_load, frame_active, rx_data);
        end
    endtask

    task automatic test_reset();
        #1;
        check_reset_outputs("reset_state");
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(6);
        check_reset_outputs("after_release_idle");
    endtask

    task automatic test_select_idle();
        int tl0, rx0;
        tl0 = tx_load_count;
        rx0 = rx_count;
        tx_data = 8'h5A;
        chip_enable = 1'b0;
        wait_cycles(100);
        tests_run++;
        if (tx_load_count - tl0 !== 1) begin
            tests_failed++;
            $display("FAIL select_tx_load: got %0d pulses, required 1", tx_load_count - tl0);
        end
        tests_run++;
        if (miso !== 1'b0 || miso_oe !== 1'b1 || frame_active !== 1'b1) begin
            tests_failed++;
            $display("FAIL select_pins: got miso=%b oe=%b fa=%b, required 0 1 1",
                     miso, miso_oe, frame_active);
        end
        tests_run++;
        if (rx_count !== rx0) begin
            tests_failed++;
            $display("FAIL select_no_rx: got %0d rx_valid, required 0", rx_count - rx0);
        end
        deselect_frame();
        tests_run++;
        if (miso_oe !== 1'b0 || frame_active !== 1'b0 || miso !== 1'b0) begin
            tests_failed++;
            $display("FAIL deselect_pins: got oe=%b fa=%b miso=%b, required 0 0 0",
                     miso_oe, frame_active, miso);
        end
    endtask

    task automatic test_rx_byte();
        logic [7:0] mi;
        int rx0;
        rx0 = rx_count;
        select_frame();
        rx_expect_q.push_back(8'hA5);
        spi_bits(8'hA5, 8, 1'b0, mi);
        deselect_frame();
        tests_run++;
        if (rx_count - rx0 !== 1) begin
            tests_failed++;
            $display("FAIL rx_a5_count: got %0d, required 1", rx_count - rx0);
        end
    endtask

    task automatic test_tx_byte();
        logic [7:0] mi;
        tx_data = 8'h3C;
        select_frame();
        rx_expect_q.push_back(8'h69);
        spi_bits(8'h69, 8, 1'b0, mi);
        deselect_frame();
        tests_run++;
        if (mi !== 8'h3C) begin
            tests_failed++;
            $display("FAIL tx_3c: got %02h, required 3c", mi);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] mi0, mi1;
        int rx0, cyc;
        rx0 = rx_count;
        tx_data = 8'hAA;
        chip_enable = 1'b0;
        cyc = 0;
        while (tx_load !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (cyc >= 20) begin
            tests_failed++;
            $display("FAIL b2b_select_load: tx_load not seen within 20 cycles");
        end
        tx_data = 8'hC3;
        wait_cycles(8);
        rx_expect_q.push_back(8'h12);
        rx_expect_q.push_back(8'h34);
        spi_bits(8'h12, 8, 1'b0, mi0);
        spi_bits(8'h34, 8, 1'b0, mi1);
        deselect_frame();
        tests_run++;
        if (mi0 !== 8'hAA || mi1 !== 8'hC3) begin
            tests_failed++;
            $display("FAIL b2b_miso: got %02h %02h, required aa c3", mi0, mi1);
        end
        tests_run++;
        if (rx_count - rx0 !== 2) begin
            tests_failed++;
            $display("FAIL b2b_rx_count: got %0d, required 2", rx_count - rx0);
        end
    endtask

    task automatic test_partial_abort();
        logic [7:0] mi;
        int rx0;
        rx0 = rx_count;
        select_frame();
        spi_bits(8'h00, 5, 1'b0, mi);
        deselect_frame();
        tests_run++;
        if (rx_count !== rx0 || rx_data !== 8'h34) begin
            tests_failed++;
            $display("FAIL partial_discard: got %0d rx, rx_data=%02h, required 0 rx, 34",
                     rx_count - rx0, rx_data);
        end
        select_frame();
        rx_expect_q.push_back(8'hFF);
        spi_bits(8'hFF, 8, 1'b0, mi);
        deselect_frame();
        tests_run++;
        if (rx_count - rx0 !== 1) begin
            tests_failed++;
            $display("FAIL partial_next: got %0d rx, required 1", rx_count - rx0);
        end
    endtask

    task automatic test_deselect_on_last();
        logic [7:0] mi;
        int rx0, tl0;
        rx0 = rx_count;
        tl0 = tx_load_count;
        select_frame();
        rx_expect_q.push_back(8'h6B);
        spi_bits(8'h6B, 8, 1'b1, mi);
        wait_cycles(10);
        tests_run++;
        if (rx_count - rx0 !== 1 || tx_load_count - tl0 !== 1) begin
            tests_failed++;
            $display("FAIL deselect_on_8th: got rx=%0d tx_load=%0d, required 1 1",
                     rx_count - rx0, tx_load_count - tl0);
        end
        tests_run++;
        if (frame_active !== 1'b0 || miso_oe !== 1'b0) begin
            tests_failed++;
            $display("FAIL deselect_on_8th_idle: got fa=%b oe=%b, required 0 0",
                     frame_active, miso_oe);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] mi;
        int rx0;
        rx0 = rx_count;
        tx_data = 8'hFF;
        select_frame();
        spi_bits(8'h81, 3, 1'b0, mi);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_frame");
        wait_cycles(3);
        rst_n = 1'b1;
        spi_bits(8'hFF, 8, 1'b0, mi);
        tests_run++;
        if (rx_count !== rx0 || miso_oe !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_wait_select: got rx=%0d oe=%b, required 0 0",
                     rx_count - rx0, miso_oe);
        end
        chip_enable = 1'b1;
        wait_cycles(10);
        select_frame();
        rx_expect_q.push_back(8'h81);
        spi_bits(8'h81, 8, 1'b0, mi);
        deselect_frame();
        tests_run++;
        if (rx_count - rx0 !== 1 || rx_data !== 8'h81) begin
            tests_failed++;
            $display("FAIL reset_then_81: got rx=%0d rx_data=%02h, required 1 81",
                     rx_count - rx0, rx_data);
        end
    endtask

    initial begin
        test_reset();
        test_select_idle();
        test_rx_byte();
        test_tx_byte();
        test_back_to_back();
        test_partial_abort();
        test_deselect_on_last();
        test_reset_mid_frame();
        tests_run++;
        if (rx_expect_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d bytes outstanding, required 0",
                     rx_expect_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
